traffic_light_controller: RTL and testbench
===========================================

Name: traffic_light_controller

Overview:
Fixed-time Moore FSM controlling a four-approach intersection:
- main road direction 1 (M1)
- main road direction 2 (M2)
- main road turn lane (MT)
- side road (S)

One clock cycle equals one second of signal time. The block is a standalone leaf driving the lamp drivers, with no handshake inputs. Phase durations are parameters. It cycles through six phases forever.

Parameters:
- T_MAIN, 7, cycles in phase S1 (M1 green, M2 green)
- T_M2Y, 2, cycles in phase S2 (M2 yellow)
- T_TURN, 5, cycles in phase S3 (MT green)
- T_TURNY, 2, cycles in phase S4 (M1 and MT yellow)
- T_SIDE, 3, cycles in phase S5 (S green)
- T_SIDEY, 2, cycles in phase S6 (S yellow)
- CNT_W, 4, width of the phase counter; must hold the largest T_* minus 1

Ports:
- clk, input, 1, system clock; rising edge active; one tick per second
- rst, input, 1, asynchronous active-low reset (0 = in reset)
- light_M1, output, 3, lamp one-hot {R,Y,G}: 100 = red, 010 = yellow, 001 = green
- light_M2, output, 3, same encoding
- light_MT, output, 3, same encoding
- light_S, output, 3, same encoding

Behaviour:
- Interface: one clock; rst is asynchronous and active-low. While rst = 0, state = S1 and count = 0 immediately, independent of clk.
- State register and a CNT_W-bit count register. Outputs are a pure combinational decode of state only (Moore); no output glitch on count.
- In each state with duration T: count increments every clk edge.
  - When count == T-1, the next edge moves to the next state and clears count to 0.
  - Each phase therefore lasts exactly T cycles.
- Sequence: S1 -> S2 -> S3 -> S4 -> S5 -> S6 -> S1. No other transitions. Default period = 21 cycles.
- Output decode per state (M1, M2, MT, S):
  - S1: G, G, R, R
  - S2: G, Y, R, R
  - S3: G, R, G, R
  - S4: Y, R, Y, R
  - S5: R, R, R, G
  - S6: R, R, R, Y
- Reset values of outputs (state S1): light_M1 = 001, light_M2 = 001, light_MT = 100, light_S = 100.
- After rst rises, the first clk edge counts as cycle 1 of S1. Deassertion is assumed synchronous to clk by the surrounding design.
- Reset asserted mid-phase: immediate return to S1 with count 0. The interrupted phase is not resumed.
- Illegal or unencoded state values: the next edge goes to S1 with count 0. All outputs decode to red (100) while in an illegal state.
- Safety invariant: S is never non-red while any of M1, M2 or MT is non-red. MT is never green while M2 is non-red.
- Every output is always exactly one-hot.

Decomposition:
- Shared package traffic_pkg:
  - state enum (S1..S6)
  - lamp constants RED = 3'b100, YEL = 3'b010, GRN = 3'b001
  - default duration constants
- Optional sub-module phase_timer: counter with load/clear and a "done" flag at count == T-1, with T muxed from state. Otherwise keep the design in a single module.

Test Plan:
- Hold rst = 0 for 3 cycles -> outputs M1 = 001, M2 = 001, MT = 100, S = 100; count stays 0 regardless of clk.
- Release rst and run 21 cycles -> phase boundaries after cycles 7, 9, 14, 16, 19, 21. Outputs match the decode list at each boundary, then return to S1 at cycle 22.
- Run 200 cycles -> the pattern repeats with exact period 21. The safety invariant and one-hot outputs are checked on every cycle.
- Assert rst asynchronously mid-S3 (between clock edges) -> outputs switch to the S1 pattern before the next clk edge. After release, S1 lasts a full 7 cycles.
- Parameter override T_MAIN = 3, T_SIDE = 1 -> S1 lasts 3 cycles, S5 lasts 1 cycle, period = 15.
- Force the state register to an unused encoding -> all outputs = 100, then S1 on the next edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic light controller
// Contents: phase enum (S1..S6), lamp encodings {R,Y,G}, default phase durations.
package traffic_pkg;

  // Six signal phases; encodings 6 and 7 are unused and treated as illegal.
  typedef enum logic [2:0] {
    S1 = 3'd0,  // M1 green, M2 green
    S2 = 3'd1,  // M2 yellow
    S3 = 3'd2,  // MT green
    S4 = 3'd3,  // M1 and MT yellow
    S5 = 3'd4,  // S green
    S6 = 3'd5   // S yellow
  } state_t;

  // Lamp one-hot encoding {R,Y,G}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Default phase durations in clock cycles (one cycle = one second).
  localparam int T_MAIN_DEF  = 7;
  localparam int T_M2Y_DEF   = 2;
  localparam int T_TURN_DEF  = 5;
  localparam int T_TURNY_DEF = 2;
  localparam int T_SIDE_DEF  = 3;
  localparam int T_SIDEY_DEF = 2;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase cycle counter with clear and terminal-count flag
// Ports: clk, rst (async active-low), clear (sync zero), limit (T-1 of current phase),
//        done (count == limit).
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time six-phase Moore FSM for a four-approach intersection
// Ports: clk (1 tick per second), rst (async active-low),
//        light_M1 / light_M2 / light_MT / light_S: lamp one-hot {R,Y,G}.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int T_MAIN  = T_MAIN_DEF,
  parameter int T_M2Y   = T_M2Y_DEF,
  parameter int T_TURN  = T_TURN_DEF,
  parameter int T_TURNY = T_TURNY_DEF,
  parameter int T_SIDE  = T_SIDE_DEF,
  parameter int T_SIDEY = T_SIDEY_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);

  state_t           state_q;
  state_t           state_d;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] limit;

  // Counter restarts on every phase change, and also when recovering from an
  // illegal state so the recovered S1 runs its full length.
  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(done | illegal),
    .limit(limit),
    .done (done)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the terminal count of the current phase
  always_comb begin
    state_d = S1;
    limit   = '0;
    illegal = 1'b0;
    case (state_q)
      S1: begin
        limit   = CNT_W'(T_MAIN - 1);
        state_d = done ? S2 : S1;
      end
      S2: begin
        limit   = CNT_W'(T_M2Y - 1);
        state_d = done ? S3 : S2;
      end
      S3: begin
        limit   = CNT_W'(T_TURN - 1);
        state_d = done ? S4 : S3;
      end
      S4: begin
        limit   = CNT_W'(T_TURNY - 1);
        state_d = done ? S5 : S4;
      end
      S5: begin
        limit   = CNT_W'(T_SIDE - 1);
        state_d = done ? S6 : S5;
      end
      S6: begin
        limit   = CNT_W'(T_SIDEY - 1);
        state_d = done ? S1 : S6;
      end
      default: begin
        illegal = 1'b1;
        state_d = S1;
      end
    endcase
  end

  // Lamp decode from state only; unknown states show all red.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state_q)
      S1: begin
        light_M1 = GRN;
        light_M2 = GRN;
      end
      S2: begin
        light_M1 = GRN;
        light_M2 = YEL;
      end
      S3: begin
        light_M1 = GRN;
        light_MT = GRN;
      end
      S4: begin
        light_M1 = YEL;
        light_MT = YEL;
      end
      S5: begin
        light_S = GRN;
      end
      S6: begin
        light_S = YEL;
      end
      default: begin
        light_M1 = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - self-checking bench for traffic_light_controller
module tb_traffic_light_controller;
  import traffic_pkg::*;

  // Lamp patterns {M1,M2,MT,S}, each {R,Y,G}
  localparam logic [11:0] P_S1  = {3'b001, 3'b001, 3'b100, 3'b100};
  localparam logic [11:0] P_S2  = {3'b001, 3'b010, 3'b100, 3'b100};
  localparam logic [11:0] P_S3  = {3'b001, 3'b100, 3'b001, 3'b100};
  localparam logic [11:0] P_S4  = {3'b010, 3'b100, 3'b010, 3'b100};
  localparam logic [11:0] P_S5  = {3'b100, 3'b100, 3'b100, 3'b001};
  localparam logic [11:0] P_S6  = {3'b100, 3'b100, 3'b100, 3'b010};
  localparam logic [11:0] P_RED = {3'b100, 3'b100, 3'b100, 3'b100};

  logic clk;
  logic rst;
  logic [2:0] m1_a, m2_a, mt_a, s_a;
  logic [2:0] m1_b, m2_b, mt_b, s_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;     // clock edges since last reset release
  bit model_en = 1'b1;

  traffic_light_controller dut (
    .clk     (clk),
    .rst     (rst),
    .light_M1(m1_a),
    .light_M2(m2_a),
    .light_MT(mt_a),
    .light_S (s_a)
  );

  traffic_light_controller #(
    .T_MAIN(3),
    .T_SIDE(1)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .light_M1(m1_b),
    .light_M2(m2_b),
    .light_MT(mt_b),
    .light_S (s_b)
  );

  wire [11:0] lamps_a = {m1_a, m2_a, mt_a, s_a};
  wire [11:0] lamps_b = {m1_b, m2_b, mt_b, s_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model time base: edge count since reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected lamps: find the phase containing position n mod period.
  function automatic logic [11:0] model_lamps(input int edges, input int d0, input int d1,
                                              input int d2, input int d3, input int d4,
                                              input int d5);
    int d [6];
    logic [11:0] pat [6];
    int per, p, acc;
    d = '{d0, d1, d2, d3, d4, d5};
    pat = '{P_S1, P_S2, P_S3, P_S4, P_S5, P_S6};
    per = d0 + d1 + d2 + d3 + d4 + d5;
    p = edges % per;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      if (p < acc + d[k]) return pat[k];
      acc += d[k];
    end
    return P_RED;
  endfunction

  function automatic bit is_onehot(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  function automatic bit is_safe(input logic [2:0] m1, input logic [2:0] m2,
                                 input logic [2:0] mt, input logic [2:0] s);
    bit side_ok, turn_ok;
    side_ok = (s == 3'b100) || (m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100);
    turn_ok = (mt != 3'b001) || (m2 == 3'b100);
    return side_ok && turn_ok;
  endfunction

  // Per-cycle compare against the model, plus one-hot and safety invariants.
  always @(negedge clk) begin
    if (model_en) begin
      check("model_dut", {20'd0, lamps_a}, {20'd0, model_lamps(n, 7, 2, 5, 2, 3, 2)});
      check("model_dut2", {20'd0, lamps_b}, {20'd0, model_lamps(n, 3, 2, 5, 2, 1, 2)});
      check("onehot_dut", 32'(is_onehot(m1_a) && is_onehot(m2_a) && is_onehot(mt_a)
                              && is_onehot(s_a)), 32'd1);
      check("onehot_dut2", 32'(is_onehot(m1_b) && is_onehot(m2_b) && is_onehot(mt_b)
                               && is_onehot(s_b)), 32'd1);
      check("safety_dut", 32'(is_safe(m1_a, m2_a, mt_a, s_a)), 32'd1);
      check("safety_dut2", 32'(is_safe(m1_b, m2_b, mt_b, s_b)), 32'd1);
    end
  end

  initial begin
    int guard;
    rst = 1'b0;

    // Reset held: S1 pattern, counter pinned at zero across edges.
    repeat (3) begin
      @(negedge clk);
      check("reset_lamps", {20'd0, lamps_a}, {20'd0, P_S1});
      check("reset_count", 32'(dut.u_timer.count_q), 32'd0);
    end
    rst = 1'b1;

    // Run more than 200 cycles with hand-computed boundary expectations.
    for (int i = 1; i <= 221; i++) begin
      @(negedge clk);
      case (i)
        6:  check("dut_c6_s1", {20'd0, lamps_a}, {20'd0, P_S1});
        7:  check("dut_c7_s2", {20'd0, lamps_a}, {20'd0, P_S2});
        9:  check("dut_c9_s3", {20'd0, lamps_a}, {20'd0, P_S3});
        14: check("dut_c14_s4", {20'd0, lamps_a}, {20'd0, P_S4});
        16: check("dut_c16_s5", {20'd0, lamps_a}, {20'd0, P_S5});
        19: check("dut_c19_s6", {20'd0, lamps_a}, {20'd0, P_S6});
        21: check("dut_c21_s1", {20'd0, lamps_a}, {20'd0, P_S1});
        42: check("dut_c42_s1", {20'd0, lamps_a}, {20'd0, P_S1});
        default: ;
      endcase
      case (i)
        2:  check("dut2_c2_s1", {20'd0, lamps_b}, {20'd0, P_S1});
        3:  check("dut2_c3_s2", {20'd0, lamps_b}, {20'd0, P_S2});
        12: check("dut2_c12_s5", {20'd0, lamps_b}, {20'd0, P_S5});
        13: check("dut2_c13_s6", {20'd0, lamps_b}, {20'd0, P_S6});
        15: check("dut2_c15_s1", {20'd0, lamps_b}, {20'd0, P_S1});
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of S3, between clock edges.
    guard = 0;
    while ((n % 21) != 10 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reach_mid_s3", 32'(n % 21), 32'd10);
    check("mid_s3_lamps", {20'd0, lamps_a}, {20'd0, P_S3});
    #2 rst = 1'b0;
    #1;
    check("async_rst_lamps", {20'd0, lamps_a}, {20'd0, P_S1});
    check("async_rst_count", 32'(dut.u_timer.count_q), 32'd0);
    @(negedge clk);
    check("async_rst_held", {20'd0, lamps_a}, {20'd0, P_S1});
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i < 7) check("post_rst_s1_full", {20'd0, lamps_a}, {20'd0, P_S1});
      else       check("post_rst_s2", {20'd0, lamps_a}, {20'd0, P_S2});
    end

    // Illegal state injection while in S3: all red, then S1 on the next edge.
    repeat (3) @(negedge clk);
    check("pre_illegal_s3", {20'd0, lamps_a}, {20'd0, P_S3});
    model_en = 1'b0;
    force dut.state_q = state_t'(3'd6);
    #1;
    check("illegal_all_red", {20'd0, lamps_a}, {20'd0, P_RED});
    release dut.state_q;
    #1;
    check("illegal_held_red", {20'd0, lamps_a}, {20'd0, P_RED});
    @(negedge clk);
    check("illegal_recover_s1", {20'd0, lamps_a}, {20'd0, P_S1});
    check("illegal_recover_cnt", 32'(dut.u_timer.count_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
